// File: rtl/control_sequencer.sv
// Microcoded control unit: T-step counter, CF/ZF flags register, halt latch; decodes opcode per T-step.
// Latency: control strobes are combinational from registered step/flags/halt state; state advances every clk.
// Backpressure: none; only HLT freezes the step counter until rst. Optional feature macro: EARLY_END_EN.
module control_sequencer #(
    parameter int STEPS = 5,
    parameter int OP_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            CARRY,
    input  logic            ZERO,
    output logic            HLT,
    output logic            MI,
    output logic            RI,
    output logic            RO,
    output logic            IO,
    output logic            II,
    output logic            AI,
    output logic            AO,
    output logic            EO,
    output logic            SUB,
    output logic            BI,
    output logic            OI,
    output logic            CE,
    output logic            CO,
    output logic            J,
    output logic            FI,
    output logic [2:0]      step,
    output logic            CF,
    output logic            ZF
);

    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    localparam logic [OP_W-1:0] OP_NOP = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_STA = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_LDI = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'h6);
    localparam logic [OP_W-1:0] OP_JC  = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OP_JZ  = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'hE);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_step;
    logic [2:0] w_step_nxt;
    logic [2:0] w_last_step;
    logic       r_cf;
    logic       r_zf;

    assign step = r_step;
    assign CF   = r_cf;
    assign ZF   = r_zf;

    // Microcode decode: one control word per (step, opcode, flags); halted forces HLT only.
    always_comb begin
        HLT = 1'b0; MI = 1'b0; RI = 1'b0; RO = 1'b0; IO  = 1'b0; II = 1'b0;
        AI  = 1'b0; AO = 1'b0; EO = 1'b0; SUB = 1'b0; BI = 1'b0; OI = 1'b0;
        CE  = 1'b0; CO = 1'b0; J  = 1'b0; FI = 1'b0;
        if (r_state == ST_HALT) begin
            HLT = 1'b1;
        end else begin
            case (r_step)
                3'd0: begin CO = 1'b1; MI = 1'b1; end
                3'd1: begin RO = 1'b1; II = 1'b1; CE = 1'b1; end
                3'd2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin IO = 1'b1; MI = 1'b1; end
                        OP_LDI: begin IO = 1'b1; AI = 1'b1; end
                        OP_JMP: begin IO = 1'b1; J  = 1'b1; end
                        // Conditional jumps look only at the latched flags, never live ALU flags.
                        OP_JC:  begin IO = r_cf; J = r_cf; end
                        OP_JZ:  begin IO = r_zf; J = r_zf; end
                        OP_OUT: begin AO = 1'b1; OI = 1'b1; end
                        OP_HLT: HLT = 1'b1;
                        default: ;
                    endcase
                end
                3'd3: begin
                    case (opcode)
                        OP_LDA:         begin RO = 1'b1; AI = 1'b1; end
                        OP_ADD, OP_SUB: begin RO = 1'b1; BI = 1'b1; end
                        OP_STA:         begin AO = 1'b1; RI = 1'b1; end
                        default: ;
                    endcase
                end
                3'd4: begin
                    case (opcode)
                        OP_ADD: begin EO = 1'b1; AI = 1'b1; FI = 1'b1; end
                        OP_SUB: begin EO = 1'b1; AI = 1'b1; SUB = 1'b1; FI = 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Final step of the current instruction; with early end, empty trailing steps are skipped.
    always_comb begin
        w_last_step = LAST_STEP;
`ifdef EARLY_END_EN
        case (opcode)
            OP_NOP:                                 w_last_step = 3'd1;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT:   w_last_step = 3'd2;
            OP_LDA, OP_STA:                         w_last_step = 3'd3;
            OP_ADD, OP_SUB:                         w_last_step = 3'd4;
            OP_HLT:                                 w_last_step = LAST_STEP;
            default:                                w_last_step = 3'd1;
        endcase
`endif
    end

    // Next-state: HLT latches the halt state and freezes the counter; otherwise step and wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        if (r_state == ST_RUN) begin
            if (HLT) begin
                w_state_nxt = ST_HALT;
            end else if (r_step >= w_last_step) begin
                w_step_nxt = 3'd0;
            end else begin
                w_step_nxt = r_step + 3'd1;
            end
        end
    end

    // Step counter and halt state registers; reset wins over halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_step  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    // Flags register loads the live ALU flags only on FI steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cf <= 1'b0;
            r_zf <= 1'b0;
        end else if (FI) begin
            r_cf <= CARRY;
            r_zf <= ZERO;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: randomized instruction stream against a table-driven reference model.
// Stimulus pushes expected per-cycle outputs into a queue; a negedge monitor pops and compares.
// Reset, fetch, flags, conditional jumps, halt freeze and mid-instruction reset are exercised.
module tb_control_sequencer;

    localparam int B_HLT = 15, B_MI = 14, B_RI = 13, B_RO = 12, B_IO = 11, B_II = 10;
    localparam int B_AI  = 9,  B_AO = 8,  B_EO = 7,  B_SUB = 6, B_BI = 5,  B_OI = 4;
    localparam int B_CE  = 3,  B_CO = 2,  B_J  = 1,  B_FI  = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       CARRY, ZERO;
    logic       HLT, MI, RI, RO, IO, II, AI, AO, EO, SUB, BI, OI, CE, CO, J, FI;
    logic [2:0] step;
    logic       CF, ZF;

    control_sequencer #(.STEPS(5), .OP_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .CARRY(CARRY), .ZERO(ZERO),
        .HLT(HLT), .MI(MI), .RI(RI), .RO(RO), .IO(IO), .II(II), .AI(AI), .AO(AO),
        .EO(EO), .SUB(SUB), .BI(BI), .OI(OI), .CE(CE), .CO(CO), .J(J), .FI(FI),
        .step(step), .CF(CF), .ZF(ZF)
    );

    always #5 clk = ~clk;

    logic [15:0] dut_word;
    assign dut_word = {HLT, MI, RI, RO, IO, II, AI, AO, EO, SUB, BI, OI, CE, CO, J, FI};

    typedef struct {
        logic [15:0] w;
        logic [2:0]  st;
        logic        cf;
        logic        zf;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    logic [15:0] ucode [16][5];
    int          m_step;
    bit          m_cf, m_zf, m_halt;

    function automatic logic [15:0] b(input int i);
        return 16'(1) << i;
    endfunction

    function automatic logic [15:0] exp_word(input logic [3:0] op);
        logic [15:0] w;
        if (m_halt) return b(B_HLT);
        w = ucode[op][m_step];
        if (m_step == 2 && ((op == 4'h7 && !m_cf) || (op == 4'h8 && !m_zf))) w = '0;
        return w;
    endfunction

    function automatic int last_step(input logic [3:0] op);
`ifdef EARLY_END_EN
        if (op == 4'hF) return 4;
        for (int s = 4; s >= 2; s--) if (ucode[op][s] != '0) return s;
        return 1;
`else
        return (op == 4'hF) ? 4 : 4;
`endif
    endfunction

    task automatic cycle(input bit r, input logic [3:0] op, input bit c, input bit z);
        logic [15:0] w;
        exp_t e;
        rst = r; opcode = op; CARRY = c; ZERO = z;
        w = exp_word(op);
        e.w = w; e.st = 3'(m_step); e.cf = m_cf; e.zf = m_zf;
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            m_step = 0; m_cf = 0; m_zf = 0; m_halt = 0;
        end else if (!m_halt) begin
            if (w[B_FI]) begin m_cf = c; m_zf = z; end
            if (w[B_HLT]) m_halt = 1;
            else if (m_step == last_step(op)) m_step = 0;
            else m_step = m_step + 1;
        end
        #1;
    endtask

    // Runs one instruction to completion (or halt); rst_chance is per-cycle odds out of 100.
    task automatic instr(input logic [3:0] op, input bit c, input bit z, input int rst_chance);
        int n = 0;
        bit r;
        do begin
            r = ($urandom_range(0, 99) < rst_chance);
            cycle(r, op, c, z);
            n++;
        end while (m_step != 0 && !m_halt && n < 8);
    endtask

    task automatic halt_then_reset(input logic [3:0] op, input int hold);
        for (int k = 0; k < hold; k++) cycle(0, op, 1'($urandom), 1'($urandom));
        cycle(1, op, 1'b0, 1'b0);
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if (dut_word !== e.w) begin
                fails++;
                $display("FAIL ctrl_word t=%0t: got %h expected %h (step %0d)", $time, dut_word, e.w, e.st);
            end
            tests++;
            if (step !== e.st) begin
                fails++;
                $display("FAIL step t=%0t: got %0d expected %0d", $time, step, e.st);
            end
            tests++;
            if ({CF, ZF} !== {e.cf, e.zf}) begin
                fails++;
                $display("FAIL flags t=%0t: got CF=%b ZF=%b expected CF=%b ZF=%b", $time, CF, ZF, e.cf, e.zf);
            end
            tests++;
            if ($countones({RO, IO, AO, EO, CO}) > 1) begin
                fails++;
                $display("FAIL bus_drivers t=%0t: got %b expected at most one set", $time, {RO, IO, AO, EO, CO});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, queue depth %0d expected 0", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        for (int o = 0; o < 16; o++) begin
            for (int s = 0; s < 5; s++) ucode[o][s] = '0;
            ucode[o][0] = b(B_CO) | b(B_MI);
            ucode[o][1] = b(B_RO) | b(B_II) | b(B_CE);
        end
        ucode[1][2]  = b(B_IO) | b(B_MI); ucode[1][3] = b(B_RO) | b(B_AI);
        ucode[2][2]  = b(B_IO) | b(B_MI); ucode[2][3] = b(B_RO) | b(B_BI);
        ucode[2][4]  = b(B_EO) | b(B_AI) | b(B_FI);
        ucode[3][2]  = b(B_IO) | b(B_MI); ucode[3][3] = b(B_RO) | b(B_BI);
        ucode[3][4]  = b(B_EO) | b(B_AI) | b(B_SUB) | b(B_FI);
        ucode[4][2]  = b(B_IO) | b(B_MI); ucode[4][3] = b(B_AO) | b(B_RI);
        ucode[5][2]  = b(B_IO) | b(B_AI);
        ucode[6][2]  = b(B_IO) | b(B_J);
        ucode[7][2]  = b(B_IO) | b(B_J);
        ucode[8][2]  = b(B_IO) | b(B_J);
        ucode[14][2] = b(B_AO) | b(B_OI);
        ucode[15][2] = b(B_HLT);

        // Initial reset edge establishes known state; nothing to check before it.
        rst = 1'b1; opcode = 4'h0; CARRY = 1'b0; ZERO = 1'b0;
        @(posedge clk); #1;
        m_step = 0; m_cf = 0; m_zf = 0; m_halt = 0;

        // Reset state and fetch, NOP full cycle
        cycle(1, 4'h0, 0, 0);
        instr(4'h0, 0, 0, 0);
        instr(4'h0, 0, 0, 0);
        // ADD with carry
        instr(4'h2, 1, 0, 0);
        // SUB to zero then JZ taken
        instr(4'h3, 1, 1, 0);
        instr(4'h8, 0, 0, 0);
        // Clear ZF then JZ not taken
        instr(4'h2, 0, 0, 0);
        instr(4'h8, 0, 1, 0);
        // Flag isolation: CF=0 latched, live CARRY=1
        instr(4'h7, 1, 1, 0);
        // Remaining opcodes once each
        instr(4'h1, 0, 0, 0); instr(4'h4, 0, 0, 0); instr(4'h5, 0, 0, 0);
        instr(4'h6, 0, 0, 0); instr(4'hE, 0, 0, 0); instr(4'hA, 0, 0, 0);
        // Reset in mid-instruction: LDA up to T3 then rst
        cycle(0, 4'h1, 0, 0); cycle(0, 4'h1, 0, 0); cycle(0, 4'h1, 0, 0); cycle(0, 4'h1, 0, 0);
        cycle(1, 4'h1, 0, 0);
        instr(4'h5, 0, 0, 0);
        // Set flags then halt and hold; reset clears everything
        instr(4'h2, 1, 1, 0);
        instr(4'hF, 0, 0, 0);
        halt_then_reset(4'hF, 12);
        cycle(0, 4'h0, 0, 0);

        // Randomized instruction stream
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h2;
            instr(op, 1'($urandom), 1'($urandom), 2);
            if (m_halt) halt_then_reset(op, $urandom_range(3, 12));
        end

        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcoded control unit of the 8-bit computer; sits directly upstream of the A/B register and ALU stage and drives its AI, BI and SUB inputs, together with every other bus load/enable strobe.
Holds the T-step counter, the latched CARRY/ZERO flags register (fed by the ALU flag outputs) and the halt latch.
Decodes the 4-bit opcode from the instruction register into one control word per T-step.

Parameters:
STEPS, 5, T-steps per instruction cycle; the step counter runs 0..STEPS-1. Only 5 is supported; minimum 5.
OP_W, 4, opcode width (upper nibble of the instruction register).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
opcode  input  OP_W  instruction register bits [7:4]
CARRY  input  1  ALU carry, combinational from ALU
ZERO  input  1  ALU zero, combinational from ALU
HLT  output  1  halt clock/system
MI  output  1  memory address register in
RI  output  1  RAM in
RO  output  1  RAM out to bus
IO  output  1  instruction register operand out to bus
II  output  1  instruction register in
AI  output  1  A register in
AO  output  1  A register out to bus
EO  output  1  ALU result out to bus
SUB  output  1  ALU subtract select
BI  output  1  B register in
OI  output  1  output register in
CE  output  1  program counter increment
CO  output  1  program counter out to bus
J  output  1  program counter load (jump)
FI  output  1  flags register in
step  output  3  current T-step (debug)
CF  output  1  latched carry flag
ZF  output  1  latched zero flag

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- State: step counter, CF, ZF, halted. All are updated on the rising edge of clk only.
- Reset: step=0, CF=0, ZF=0, halted=0. Reset has priority over every other event, including in mid-instruction and while halted.
- Control outputs are combinational from (step, opcode, CF, ZF, halted). With halted=0 and step=0, the outputs are CO=MI=1 immediately after reset; all other strobes are 0.
- Step counter: increments each cycle; wraps from STEPS-1 to 0.
- Fetch, identical for all opcodes:
  - T0: CO MI
  - T1: RO II CE
- Execute, T2..T4. Strobes not listed are 0.
  - 0x0 NOP: none
  - 0x1 LDA: T2 IO MI; T3 RO AI
  - 0x2 ADD: T2 IO MI; T3 RO BI; T4 EO AI FI
  - 0x3 SUB: T2 IO MI; T3 RO BI; T4 EO AI SUB FI
  - 0x4 STA: T2 IO MI; T3 AO RI
  - 0x5 LDI: T2 IO AI
  - 0x6 JMP: T2 IO J
  - 0x7 JC: T2 IO J only if CF=1; otherwise nothing
  - 0x8 JZ: T2 IO J only if ZF=1; otherwise nothing
  - 0xE OUT: T2 AO OI
  - 0xF HLT: T2 HLT
  - 0x9-0xD: behave as NOP
- Flags register:
  - On an edge with FI=1: CF<=CARRY, ZF<=ZERO.
  - Otherwise CF and ZF hold.
  - Jump conditions use the registered CF/ZF, never the live CARRY/ZERO.
- Halt:
  - On the edge ending a step where HLT=1, halted<=1 and the step counter freezes.
  - While halted: HLT=1 and all other strobes are 0. step, CF and ZF hold.
  - Only rst clears halted.
- Invariant: at most one bus driver (RO, IO, AO, EO, CO) is asserted in any step.

Optional Feature:
Macro EARLY_END_EN.
- Defined: after the final active step of an instruction, the counter returns to 0 instead of stepping through empty steps.
  - Last active step per opcode: NOP=T1; LDI, JMP, JC, JZ, OUT = T2; LDA, STA = T3; ADD, SUB = T4.
  - A not-taken JC or JZ ends at T2.
  - Undefined opcodes end at T1.
  - HLT does not end early; halt behaviour is unchanged.
- Undefined: every instruction takes exactly STEPS cycles.

Test Plan:
- Reset/fetch: rst=1 for one cycle, opcode=0x0 -> step=0, CO=MI=1; next cycle RO=II=CE=1; step sequence 0,1,2,3,4,0.
- ADD with carry: opcode=0x2, CARRY=1, ZERO=0 -> at T4 EO=AI=FI=1 and SUB=0; after that edge CF=1, ZF=0.
- SUB to zero, then JZ: opcode=0x3 with CARRY=1, ZERO=1 -> T4 asserts SUB=1 and flags latch CF=1, ZF=1. Next instruction opcode=0x8 -> T2 asserts IO=J=1. Repeat with ZF=0 -> J=0.
- Flag isolation: CF=0 latched, live CARRY=1, opcode=0x7 -> J=0 at T2; CF stays 0 because FI=0.
- Halt: opcode=0xF -> T2 HLT=1; afterwards step frozen at 2, HLT=1, all other strobes 0 for 10+ cycles; rst=1 -> step=0, halted=0, CF=ZF=0.
- Reset mid-instruction: rst at T3 of LDA -> next cycle step=0 with CO=MI=1. With EARLY_END_EN: LDI finishes in 3 cycles, giving step sequence 0,1,2,0.
